spi_instr_frontend: RTL and testbench

//  SPI peripheral front end for the execution unit. Deserialises one instruction frame per cs_n window into

---
 rtl/spi_cpu_pkg.sv | 30 +++
 rtl/spi_sync.sv | 31 +++
 rtl/spi_instr_frontend.sv | 135 +++++++++++++
 tb/tb_spi_instr_frontend.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cpu_pkg.sv
// Shared widths, FSM encoding and sizing helpers for the SPI instruction front end.
// Optional feature macro: SPI_PARITY_EN (adds a trailing odd-parity bit on mosi and miso).
package spi_cpu_pkg;

  localparam int DEF_OPCODE_W  = 4;
  localparam int DEF_OPERAND_W = 8;
  localparam int DEF_RESULT_W  = 8;
  localparam int FRAME_BITS    = DEF_OPCODE_W + DEF_OPERAND_W;

`ifdef SPI_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  localparam int CNT_W = $clog2(FRAME_BITS + PARITY_BITS + 2);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2,
    CHECK     = 2'd3
  } state_t;

  // Counter must hold 0 .. frame_len+1 (saturation value marks "too long").
  function automatic int cnt_width(input int frame_len);
    return $clog2(frame_len + 2);
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchroniser for an asynchronous pin plus single-clk rise/fall strobes.
// Resets low, so a cs_n pin must be seen high before the front end treats the bus as idle.
module spi_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  // NOTE: flops are written with <= so every stage samples the previous stage's old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_instr_frontend.sv
// SPI mode-0 peripheral: deserialises opcode/operand per cs_n window, returns cpu_out on miso.
// Optional feature macro: SPI_PARITY_EN.
module spi_instr_frontend
  import spi_cpu_pkg::*;
#(
  parameter int OPCODE_W  = DEF_OPCODE_W,
  parameter int OPERAND_W = DEF_OPERAND_W,
  parameter int RESULT_W  = DEF_RESULT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclk,
  input  logic                 cs_n,
  input  logic                 mosi,
  output logic                 miso,
  input  logic [RESULT_W-1:0]  cpu_out,
  output logic [OPCODE_W-1:0]  opcode,
  output logic [OPERAND_W-1:0] operand,
  output logic                 start,
  output logic                 busy,
  output logic                 frame_err
);

  localparam int FRAME_LEN = OPCODE_W + OPERAND_W + PARITY_BITS;
  localparam int TX_LEN    = RESULT_W + PARITY_BITS;
  localparam int CW        = cnt_width(FRAME_LEN);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_LEN);
  localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_LEN + 1);

  logic sclk_sync_unused, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync u_sync_sclk (.clk(clk), .rst_n(rst_n), .async_i(sclk),
                        .sync_o(sclk_sync_unused), .rise_o(sclk_rise), .fall_o(sclk_fall));
  spi_sync u_sync_cs   (.clk(clk), .rst_n(rst_n), .async_i(cs_n),
                        .sync_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall_unused));
  spi_sync u_sync_mosi (.clk(clk), .rst_n(rst_n), .async_i(mosi),
                        .sync_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused));

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q;
  logic [FRAME_LEN-1:0]   rx_q;
  logic [TX_LEN-1:0]      tx_q, tx_load;
  logic                   miso_q, start_q, err_q;
  logic                   start_d, err_d, parity_ok, frame_ok;
  logic [OPCODE_W-1:0]    opcode_q;
  logic [OPERAND_W-1:0]   operand_q;

`ifdef SPI_PARITY_EN
  assign tx_load   = {cpu_out, ~^cpu_out};
  assign parity_ok = ^rx_q;
`else
  assign tx_load   = cpu_out;
  assign parity_ok = 1'b1;
`endif

  assign frame_ok = (cnt_q == CNT_FULL) && parity_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT_IDLE;
    else        state_q <= state_d;
  end

  // IDLE reacts to the cs_n level, so a fall that landed during CHECK is still honoured.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      WAIT_IDLE: if (cs_s)    state_d = IDLE;
      IDLE:      if (!cs_s)   state_d = SHIFT;
      SHIFT:     if (cs_rise) state_d = CHECK;
      CHECK:                  state_d = IDLE;
      default:                state_d = WAIT_IDLE;
    endcase
  end

  always_comb begin
    start_d = 1'b0;
    err_d   = 1'b0;
    if (state_q == CHECK) begin
      start_d = frame_ok;
      err_d   = !frame_ok;
    end
  end

  assign busy = (state_q == SHIFT);

  // NOTE: datapath registers are reset as well, so outputs are defined right after rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      miso_q    <= 1'b0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
      opcode_q  <= '0;
      operand_q <= '0;
    end else begin
      start_q <= start_d;
      err_q   <= err_d;
      if (start_d) begin
        opcode_q  <= rx_q[FRAME_LEN-1 -: OPCODE_W];
        operand_q <= rx_q[FRAME_LEN-1-OPCODE_W -: OPERAND_W];
      end
      if (state_q == IDLE && !cs_s) begin
        tx_q   <= tx_load;
        miso_q <= tx_load[TX_LEN-1];
        cnt_q  <= '0;
      end else if (state_q == SHIFT) begin
        // cs_n rising wins over a coincident sclk edge: that bit is dropped.
        if (cs_rise) begin
          miso_q <= 1'b0;
        end else begin
          if (sclk_rise) begin
            rx_q <= {rx_q[FRAME_LEN-2:0], mosi_s};
            if (cnt_q != CNT_SAT) cnt_q <= cnt_q + CW'(1);
          end
          if (sclk_fall) begin
            tx_q   <= {tx_q[TX_LEN-2:0], 1'b0};
            miso_q <= tx_q[TX_LEN-2];
          end
        end
      end
    end
  end

  assign miso      = miso_q;
  assign start     = start_q;
  assign frame_err = err_q;
  assign opcode    = opcode_q;
  assign operand   = operand_q;

endmodule

// File: tb/tb_spi_instr_frontend.sv
// Directed bench for spi_instr_frontend with a scoreboard of expected opcode/operand pairs.
// Honours SPI_PARITY_EN the same way as the design.
module tb_spi_instr_frontend;
  import spi_cpu_pkg::*;

  localparam int OW = DEF_OPCODE_W;
  localparam int DW = DEF_OPERAND_W;
  localparam int RW = DEF_RESULT_W;
  localparam int FLEN = FRAME_BITS + PARITY_BITS;
  localparam int TLEN = RW + PARITY_BITS;

  logic clk, rst_n, sclk, cs_n, mosi, miso, start, busy, frame_err;
  logic [RW-1:0] cpu_out;
  logic [OW-1:0] opcode;
  logic [DW-1:0] operand;

  spi_instr_frontend dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .cpu_out(cpu_out), .opcode(opcode), .operand(operand), .start(start),
    .busy(busy), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int start_seen = 0;
  int err_seen = 0;
  int exp_starts = 0;
  int exp_errs = 0;
  logic [OW+DW-1:0] sb_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each start must match the oldest frame expected to be accepted.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (start === 1'b1) begin
        logic [OW+DW-1:0] e;
        start_seen++;
        check("sb_nonempty_at_start", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("opcode", 32'(opcode), 32'(e[OW+DW-1 -: OW]));
          check("operand", 32'(operand), 32'(e[DW-1:0]));
        end
      end
      if (frame_err === 1'b1) err_seen++;
    end
  end

  function automatic logic [15:0] make_frame(input logic [OW-1:0] op, input logic [DW-1:0] opd,
                                             input logic flip);
`ifdef SPI_PARITY_EN
    return 16'({op, opd, (~^{op, opd}) ^ flip});
`else
    return 16'({op, opd, flip}) >> 1;
`endif
  endfunction

  function automatic logic [15:0] tx_word(input logic [RW-1:0] c);
`ifdef SPI_PARITY_EN
    return 16'({c, ~^c});
`else
    return 16'(c);
`endif
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low(input int h);
    cs_n = 1'b0;
    wait_clk(2 * h);
  endtask

  task automatic cs_high(input int h);
    wait_clk(h);
    cs_n = 1'b1;
  endtask

  // Shifts n bits MSB first; miso is checked at the end of each sclk high phase.
  task automatic send_bits(input logic [15:0] d, input int n, input int first, input int h,
                           input logic [15:0] tx, input logic chk);
    for (int i = 0; i < n; i++) begin
      logic eb;
      mosi = d[n-1-i];
      wait_clk(h);
      sclk = 1'b1;
      wait_clk(h);
      eb = (first + i < TLEN) ? tx[TLEN-1-(first+i)] : 1'b0;
      if (chk) check("miso_bit", 32'(miso), 32'(eb));
      sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [15:0] f, input int n, input int h,
                           input logic [RW-1:0] cpu, input logic good);
    cpu_out = cpu;
    if (good) begin
      sb_q.push_back((OW+DW)'(f >> PARITY_BITS));
      exp_starts++;
    end else begin
      exp_errs++;
    end
    cs_low(h);
    send_bits(f, n, 0, h, tx_word(cpu), 1'b1);
    cs_high(h);
    wait_clk(8);
  endtask

  initial begin
    logic [15:0] f, f2;
    int lat;
    rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0; cpu_out = '0;
    wait_clk(3);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_opcode", 32'(opcode), 32'd0);
    check("rst_operand", 32'(operand), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    wait_clk(5);

    // Frame 0x3A5 with latency from cs_n rise to start
    f = make_frame(4'h3, 8'hA5, 1'b0);
    cpu_out = 8'h5A;
    sb_q.push_back(12'h3A5); exp_starts++;
    cs_low(2);
    check("busy_in_frame", 32'(busy), 32'd1);
    send_bits(f, FLEN, 0, 2, tx_word(8'h5A), 1'b1);
    wait_clk(2);
    cs_n = 1'b1;
    lat = 99;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (start === 1'b1) begin lat = k; break; end
    end
    check("start_latency", 32'(lat), 32'd4);
    wait_clk(4);
    check("t1_opcode", 32'(opcode), 32'h3);
    check("t1_operand", 32'(operand), 32'hA5);
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_no_err", 32'(err_seen), 32'(exp_errs));

    // miso returns the cpu_out snapshot even when cpu_out changes mid-frame
    cpu_out = 8'hC3;
    sb_q.push_back(12'h3A5); exp_starts++;
    cs_low(2);
    send_bits(f >> (FLEN - 4), 4, 0, 2, tx_word(8'hC3), 1'b1);
    cpu_out = 8'h3C;
    send_bits(f, FLEN - 4, 4, 2, tx_word(8'hC3), 1'b1);
    cs_high(2);
    wait_clk(8);
    check("t2_miso_idle", 32'(miso), 32'd0);

    // Wrong bit counts: frame_err only, outputs keep last good values
    run_frame(f >> 1, FLEN - 1, 2, 8'h11, 1'b0);
    run_frame({f[14:0], 1'b1}, FLEN + 1, 2, 8'h22, 1'b0);
    check("t3_err_count", 32'(err_seen), 32'(exp_errs));
    check("t3_start_count", 32'(start_seen), 32'(exp_starts));
    check("t3_opcode_held", 32'(opcode), 32'h3);
    check("t3_operand_held", 32'(operand), 32'hA5);

    // Reset after bit 6, released while cs_n still low: the frame is dropped
    f2 = make_frame(4'h7, 8'h77, 1'b0);
    cs_low(2);
    send_bits(f2 >> (FLEN - 6), 6, 0, 2, tx_word(cpu_out), 1'b0);
    rst_n = 1'b0;
    wait_clk(2);
    check("t4_rst_opcode", 32'(opcode), 32'd0);
    check("t4_rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    wait_clk(3);
    send_bits(f2, FLEN - 6, 6, 2, tx_word(cpu_out), 1'b0);
    cs_high(2);
    wait_clk(8);
    check("t4_no_start", 32'(start_seen), 32'(exp_starts));
    check("t4_no_err", 32'(err_seen), 32'(exp_errs));
    run_frame(make_frame(4'h1, 8'hFF, 1'b0), FLEN, 2, 8'h96, 1'b1);
    check("t4_opcode", 32'(opcode), 32'h1);
    check("t4_operand", 32'(operand), 32'hFF);

    // Back-to-back frames, cs_n high for one sclk period
    f = make_frame(4'h2, 8'h12, 1'b0);
    f2 = make_frame(4'h4, 8'h34, 1'b0);
    sb_q.push_back(12'h212); sb_q.push_back(12'h434); exp_starts += 2;
    cpu_out = 8'hA1;
    cs_low(2);
    send_bits(f, FLEN, 0, 2, tx_word(8'hA1), 1'b1);
    cs_high(2);
    wait_clk(4);
    cpu_out = 8'h5E;
    cs_low(2);
    send_bits(f2, FLEN, 0, 2, tx_word(8'h5E), 1'b1);
    cs_high(2);
    wait_clk(8);
    check("t5_start_count", 32'(start_seen), 32'(exp_starts));
    check("t5_opcode", 32'(opcode), 32'h4);
    check("t5_operand", 32'(operand), 32'h34);

    // Oversampling sweep 4x..16x with random payloads
    for (int k = 0; k < 4; k++) begin
      logic [OW-1:0] op;
      logic [DW-1:0] opd;
      op  = OW'($urandom_range(0, 15));
      opd = DW'($urandom_range(0, 255));
      run_frame(make_frame(op, opd, 1'b0), FLEN, 2 + 2 * k, RW'($urandom_range(0, 255)), 1'b1);
      check("sweep_opcode", 32'(opcode), 32'(op));
      check("sweep_operand", 32'(operand), 32'(opd));
    end

    // sclk activity with cs_n high is ignored
    for (int k = 0; k < 4; k++) begin
      sclk = 1'b1; wait_clk(2); sclk = 1'b0; wait_clk(2);
    end
    wait_clk(4);
    check("idle_sclk_busy", 32'(busy), 32'd0);
    check("idle_sclk_err", 32'(err_seen), 32'(exp_errs));
    check("idle_sclk_miso", 32'(miso), 32'd0);

    // Zero-length frame
    cs_n = 1'b0; wait_clk(4); cs_n = 1'b1; exp_errs++;
    wait_clk(8);
    check("zero_len_err", 32'(err_seen), 32'(exp_errs));

`ifdef SPI_PARITY_EN
    run_frame(make_frame(4'h3, 8'hA5, 1'b0), FLEN, 2, 8'h0F, 1'b1);
    check("par_good_opcode", 32'(opcode), 32'h3);
    run_frame(make_frame(4'h6, 8'h66, 1'b1), FLEN, 2, 8'hF0, 1'b0);
    check("par_bad_err", 32'(err_seen), 32'(exp_errs));
    check("par_bad_held", 32'(operand), 32'hA5);
`endif

    check("final_start_count", 32'(start_seen), 32'(exp_starts));
    check("final_err_count", 32'(err_seen), 32'(exp_errs));
    check("final_sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
